// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between four memory requesters, the arbiter and a shared memory port.
// The arbiter uses the slave modport; requesters and memory sit on the master side.
interface mem_port_arbiter_if #(
  parameter int WORD_WIDTH = 16
);

  logic [3:0]              req;
  logic [4*WORD_WIDTH-1:0] req_addr;
  logic [3:0]              req_wr_en;
  logic [4*WORD_WIDTH-1:0] req_wr_data;
  logic [3:0]              grant;
  logic [WORD_WIDTH-1:0]   address;
  logic                    mem_wr_en;
  logic [WORD_WIDTH-1:0]   mem_wr_data;
  logic [WORD_WIDTH-1:0]   data_in;
  logic [WORD_WIDTH-1:0]   rd_data;
  logic [3:0]              rd_valid;
  logic                    timeout;

  modport slave (
    input  req, req_addr, req_wr_en, req_wr_data, data_in,
    output grant, address, mem_wr_en, mem_wr_data, rd_data, rd_valid, timeout
  );

  modport master (
    output req, req_addr, req_wr_en, req_wr_data, data_in,
    input  grant, address, mem_wr_en, mem_wr_data, rd_data, rd_valid, timeout
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between four requesters, with read-data return.
// Optional grant-hold watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clock,
  input logic               nreset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  logic [3:0]            grant_q, grant_d;
  logic [1:0]            last_q, last_d;
  logic [3:0]            rd_valid_q, rd_valid_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [1:0]            owner_s;
  logic [3:0]            eligible_s;
  logic [1:0]            pick_s;
  logic                  pick_found_s;
  logic [1:0]            cand_s;
  logic                  hit_s;
  logic [WORD_WIDTH-1:0] addr_s;
  logic [WORD_WIDTH-1:0] wdata_s;
  logic                  wen_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    owner_s = 2'd0;
    case (grant_q)
      4'b0001: owner_s = 2'd0;
      4'b0010: owner_s = 2'd1;
      4'b0100: owner_s = 2'd2;
      4'b1000: owner_s = 2'd3;
      default: owner_s = 2'd0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  assign eligible_s = bus.req & ~mask_q;
`else
  assign eligible_s = bus.req;
`endif

  // Search starts just after the previous owner, so every requester gets a turn.
  always_comb begin
    pick_s       = 2'd0;
    pick_found_s = 1'b0;
    cand_s       = 2'd0;
    hit_s        = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand_s       = last_q + 2'(k);
      hit_s        = ~pick_found_s & eligible_s[cand_s];
      pick_s       = hit_s ? cand_s : pick_s;
      pick_found_s = pick_found_s | hit_s;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = {CNT_W{1'b0}};
    mask_d     = mask_q & bus.req;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_d = 4'b0001 << pick_s;
          state_d = BUSY;
        end else begin
          grant_d = 4'b0000;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!bus.req[owner_s]) begin
          grant_d = 4'b0000;
          last_d  = owner_s;
          state_d = IDLE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + CNT_W'(1'b1);
          if (hold_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            // Revoked owner stays masked until it lets go of its request.
            grant_d    = 4'b0000;
            last_d     = owner_s;
            state_d    = IDLE;
            timeout_d  = 1'b1;
            mask_d     = mask_d | grant_q;
            hold_cnt_d = {CNT_W{1'b0}};
          end else begin
            grant_d = grant_q;
            state_d = BUSY;
          end
`else
          grant_d = grant_q;
          state_d = BUSY;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // Every granted cycle without a write strobe is a read answered on the next cycle.
  always_comb begin
    rd_valid_d = grant_q & ~bus.req_wr_en;
    if (|rd_valid_d) begin
      rd_data_d = bus.data_in;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_comb begin
    addr_s  = {WORD_WIDTH{1'b0}};
    wdata_s = {WORD_WIDTH{1'b0}};
    wen_s   = |(grant_q & bus.req_wr_en);
    for (int i = 0; i < 4; i++) begin
      addr_s  = addr_s  | (bus.req_addr[i*WORD_WIDTH +: WORD_WIDTH]    & {WORD_WIDTH{grant_q[i]}});
      wdata_s = wdata_s | (bus.req_wr_data[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{grant_q[i]}});
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      last_q     <= 2'd3;
      rd_valid_q <= 4'b0000;
      rd_data_q  <= {WORD_WIDTH{1'b0}};
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= {CNT_W{1'b0}};
      mask_q     <= 4'b0000;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.address     = addr_s;
  assign bus.mem_wr_en   = wen_s;
  assign bus.mem_wr_data = wdata_s;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule
